// File: rtl/cam_capture_pkg.sv
// cam_capture_pkg: register map, bit positions and event entry layout
// shared by the camera capture FIFO block.
package cam_capture_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_TSTAMP = 2'd3;

  localparam int VALID_BIT  = 31;
  localparam int OVF_BIT    = 31;
  localparam int FULL_BIT   = 30;
  localparam int IRQ_EN_BIT = 31;

  localparam int STAMP_W = 32;

  typedef logic [STAMP_W-1:0] stamp_t;

  // Widest entry: stamp above a right-aligned {ch, val} event.
  typedef struct packed {
    stamp_t      stamp;
    logic [30:0] ev;
  } cam_entry_t;

  function automatic int ch_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cam_event_fifo.sv
// cam_event_fifo: single-clock FIFO with occupancy count,
// push ignored when full, pop ignored when empty.
module cam_event_fifo
  import cam_capture_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cam_capture_fifo.sv
// cam_capture_fifo: per-channel change detect, round-robin event FIFO, Avalon-MM regs.
// Optional entry timestamps with CAM_CAPTURE_TIMESTAMP_EN.
module cam_capture_fifo
  import cam_capture_pkg::*;
#(
  parameter int  NUM_CH     = 10,
  parameter int  DATA_W     = 15,
  parameter int  FIFO_DEPTH = 64,
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*DATA_W-1:0] cam_in,
  input  logic [1:0]               avs_address,
  input  logic                     avs_read,
  input  logic                     avs_write,
  input  logic [31:0]              avs_writedata,
  output logic [31:0]              avs_readdata,
  output logic                     irq
);

  localparam int EV_W  = DATA_W + CH_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef CAM_CAPTURE_TIMESTAMP_EN
  localparam int FW = STAMP_W + EV_W;
`else
  localparam int FW = EV_W;
`endif

  logic [DATA_W-1:0] sync1 [NUM_CH];
  logic [DATA_W-1:0] sync2 [NUM_CH];
  logic [DATA_W-1:0] last  [NUM_CH];
  logic [DATA_W-1:0] pval  [NUM_CH];

  logic [NUM_CH-1:0] enable, en_next;
  logic [NUM_CH-1:0] pend, chg, gnt, lost;
  logic              irq_en, ovf, ovf_clr;
  logic [CH_W-1:0]   last_gnt, gnt_idx;
  logic [DATA_W-1:0] gnt_val;
  logic              gnt_vld;

  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [FW-1:0]     fifo_din, fifo_dout;
  logic [31:0]       rd_mux, ts_rd;
  logic              rd_data, wr_ctrl, wr_stat;
  logic              unused_wd;

  assign unused_wd = ^avs_writedata;
  assign rd_data   = avs_read  & (avs_address == REG_DATA);
  assign wr_ctrl   = avs_write & (avs_address == REG_CTRL);
  assign wr_stat   = avs_write & (avs_address == REG_STATUS);
  assign ovf_clr   = wr_stat & avs_writedata[OVF_BIT];
  assign en_next   = wr_ctrl ? avs_writedata[NUM_CH-1:0] : enable;
  assign lost      = chg & pend & ~gnt;
  assign irq       = ~fifo_empty & irq_en;

  function automatic int rr_idx(logic [CH_W-1:0] base, int off);
    int j;
    j = int'(base) + off;
    return (j >= NUM_CH) ? j - NUM_CH : j;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        sync1[k] <= '0;
        sync2[k] <= '0;
        last[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        sync1[k] <= cam_in[k*DATA_W +: DATA_W];
        sync2[k] <= sync1[k];
        last[k]  <= sync2[k];
      end
    end
  end

  always_comb begin
    chg = '0;
    for (int k = 0; k < NUM_CH; k++)
      chg[k] = enable[k] & (sync2[k] != last[k]);
  end

  // First pending channel after the last grant wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_val = '0;
    if (!fifo_full) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (!gnt_vld && pend[k] && rr_idx(last_gnt, i) == k) begin
            gnt_vld = 1'b1;
            gnt[k]  = 1'b1;
            gnt_idx = CH_W'(k);
            gnt_val = pval[k];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) pval[k] <= '0;
      pend     <= '0;
      last_gnt <= '0;
      enable   <= '0;
      irq_en   <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (chg[k]) pval[k] <= sync2[k];
        if (!en_next[k])  pend[k] <= 1'b0;
        else if (chg[k])  pend[k] <= 1'b1;
        else if (gnt[k])  pend[k] <= 1'b0;
      end
      if (gnt_vld) last_gnt <= gnt_idx;
      ovf <= (|lost) | (ovf & ~ovf_clr);
      if (wr_ctrl) begin
        enable <= avs_writedata[NUM_CH-1:0];
        irq_en <= avs_writedata[IRQ_EN_BIT];
      end
    end
  end

`ifdef CAM_CAPTURE_TIMESTAMP_EN
  stamp_t ts_cnt, ts_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt <= '0;
      ts_q   <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (rd_data && !fifo_empty) ts_q <= fifo_dout[FW-1 -: STAMP_W];
    end
  end

  assign fifo_din = {ts_cnt, gnt_idx, gnt_val};
  assign ts_rd    = ts_q;
`else
  assign fifo_din = {gnt_idx, gnt_val};
  assign ts_rd    = '0;
`endif

  cam_event_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (gnt_vld),
    .din     (fifo_din),
    .pop     (rd_data),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (avs_address == REG_DATA): begin
        if (!fifo_empty) begin
          rd_mux[VALID_BIT]  = 1'b1;
          rd_mux[EV_W-1:0]   = fifo_dout[EV_W-1:0];
        end
      end
      (avs_address == REG_STATUS): begin
        rd_mux[OVF_BIT]     = ovf;
        rd_mux[FULL_BIT]    = fifo_full;
        rd_mux[CNT_W-1:0]   = fifo_count;
      end
      (avs_address == REG_CTRL): begin
        rd_mux[NUM_CH-1:0]  = enable;
        rd_mux[IRQ_EN_BIT]  = irq_en;
      end
      (avs_address == REG_TSTAMP): rd_mux = ts_rd;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) avs_readdata <= '0;
    else          avs_readdata <= avs_read ? rd_mux : '0;
  end

endmodule
